// File: rtl/sram_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the SRAM access arbiter: FSM state encoding,
// default RAM geometry and the port identifiers used by the arbitration.
// No ports (package).
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_READ   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage : ram_arb_pkg

// File: rtl/sram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter_if
// Requester-side bus of the SRAM access arbiter: two request channels
// (port 0 = CPU datapath, port 1 = external loader) plus the shared read
// data return.
//   req0/req1      request, held until the matching grant
//   we0/we1        1 = write, 0 = read
//   addr0/addr1    access address
//   wdata0/wdata1  write data
//   gnt0/gnt1      one-cycle grant pulse
//   rvalid0/1      one-cycle read-data-valid pulse
//   rdata          shared read data, qualified by rvalid0/1
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sram_access_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface : sram_access_arbiter_if

// File: rtl/sram_access_arbiter_arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2
// Combinational winner select between two requesters.
//   req0, req1  pending requests
//   last_gnt    port granted by the previous access
//   winner      selected port (0 = CPU, 1 = loader); only meaningful
//               when at least one request is pending
// Build option: ARB_ROUND_ROBIN_EN defined -> a tie goes to the port that
// was not granted last; undefined -> port 0 always wins a tie.
// ---------------------------------------------------------------------------
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else begin
            winner = req0 ? PORT_CPU : PORT_LOADER;
        end
    end
`else
    // Fixed priority: last_gnt is tracked for debug visibility only.
    logic last_gnt_unused;
    assign last_gnt_unused = last_gnt;

    always_comb begin
        winner = req0 ? PORT_CPU : PORT_LOADER;
    end
`endif

endmodule : arb_pick2

// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
// Shares a single-port 16x8 static RAM between the CPU datapath (port 0)
// and an external loader (port 1). Arbitrates in IDLE, sequences the RAM
// strobes and returns read data with a one-cycle valid pulse.
// Ports:
//   CLK        clock, rising edge
//   RESET_N    asynchronous active-low reset
//   bus        requester interface (slave modport)
//   ram_cs     RAM chip select
//   ram_we     RAM write enable
//   ram_rd     RAM output enable
//   ram_addr   RAM address
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data
//   busy       high in any state but IDLE
// Build option: ARB_ROUND_ROBIN_EN (see arb_pick2).
// Sequence: IDLE -> ACCESS -> IDLE (write) | READ -> RESP -> IDLE (read).
// ---------------------------------------------------------------------------
module sram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                  CLK,
    input  logic                  RESET_N,
    sram_access_arbiter_if.slave  bus,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_rd,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  busy
);

    state_t            state_q,    state_d;
    logic              winner_q,   winner_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              last_gnt_q, last_gnt_d;

    logic pick;

    arb_pick2 u_pick (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .last_gnt (last_gnt_q),
        .winner   (pick)
    );

    // State and capture registers. last_gnt resets to 1 so port 0 wins
    // the first tie in round-robin mode.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            winner_q   <= PORT_CPU;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state and capture logic. Requests are only looked at in IDLE;
    // once captured the access runs to completion even if req drops.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    winner_d = pick;
                    we_d     = (pick == PORT_LOADER) ? bus.we1    : bus.we0;
                    addr_d   = (pick == PORT_LOADER) ? bus.addr1  : bus.addr0;
                    wdata_d  = (pick == PORT_LOADER) ? bus.wdata1 : bus.wdata0;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                last_gnt_d = winner_q;
                state_d    = we_q ? ST_IDLE : ST_READ;
            end
            ST_READ: begin
                rdata_d = ram_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobe and handshake decode, purely from registered state.
    always_comb begin
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_rd      = 1'b0;
        bus.gnt0    = 1'b0;
        bus.gnt1    = 1'b0;
        bus.rvalid0 = 1'b0;
        bus.rvalid1 = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_ACCESS: begin
                ram_cs   = 1'b1;
                ram_we   = we_q;
                bus.gnt0 = (winner_q == PORT_CPU);
                bus.gnt1 = (winner_q == PORT_LOADER);
            end
            ST_READ: begin
                ram_cs = 1'b1;
                ram_rd = 1'b1;
            end
            ST_RESP: begin
                bus.rvalid0 = (winner_q == PORT_CPU);
                bus.rvalid1 = (winner_q == PORT_LOADER);
            end
            default: begin
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign bus.rdata = rdata_q;

endmodule : sram_access_arbiter

// File: tb/tb_sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_access_arbiter
// Directed bench for sram_access_arbiter with a behavioural 16x8 RAM
// (synchronous write, asynchronous read). Honours ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_sram_access_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       ram_cs, ram_we, ram_rd, busy;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    sram_access_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    sram_access_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_rd    (ram_rd),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always @(posedge CLK) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int port, input logic we, input logic [3:0] a, input logic [7:0] d);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic clr_req(input int port);
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    task automatic wait_gnt(output int who);
        who = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.gnt0) begin who = 0; break; end
            if (bus.gnt1) begin who = 1; break; end
        end
        if (who < 0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rvalid(output int who);
        who = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rvalid0) begin who = 0; break; end
            if (bus.rvalid1) begin who = 1; break; end
        end
        if (who < 0) chk("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input int port, input logic [3:0] a, input logic [7:0] d);
        int who;
        set_req(port, 1'b1, a, d);
        wait_gnt(who);
        chk("wr_gnt_port", who, port);
        chk("wr_ram_addr", ram_addr, a);
        clr_req(port);
        tick();
    endtask

    task automatic do_read(input int port, input logic [3:0] a, input logic [7:0] exp);
        int who;
        set_req(port, 1'b0, a, 8'h00);
        wait_gnt(who);
        chk("rd_gnt_port", who, port);
        clr_req(port);
        wait_rvalid(who);
        chk("rd_rvalid_port", who, port);
        chk("rd_rdata", bus.rdata, exp);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int g_cnt, r_cnt;
        logic [7:0] cap;
        int exp_tie [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_tie = '{0, 1, 0, 1};
`else
        exp_tie = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        // Reset state
        chk("rst_busy",    busy,        0);
        chk("rst_gnt",     {bus.gnt0, bus.gnt1}, 0);
        chk("rst_rvalid",  {bus.rvalid0, bus.rvalid1}, 0);
        chk("rst_strobes", {ram_cs, ram_we, ram_rd}, 0);
        chk("rst_addr",    ram_addr,    0);
        chk("rst_wdata",   ram_wdata,   0);
        chk("rst_rdata",   bus.rdata,   0);
        RESET_N = 1'b1;
        tick();

        // Port 0 write, cycle by cycle, then port 1 read-back
        set_req(0, 1'b1, 4'h3, 8'hA5);
        tick();
        chk("t2_gnt0",   bus.gnt0, 1);
        chk("t2_gnt1",   bus.gnt1, 0);
        chk("t2_cs_we",  {ram_cs, ram_we}, 2'b11);
        chk("t2_addr",   ram_addr,  4'h3);
        chk("t2_wdata",  ram_wdata, 8'hA5);
        clr_req(0);
        tick();
        chk("t2_mem3",   mem[3], 8'hA5);
        chk("t2_idle",   {busy, bus.gnt0}, 0);
        set_req(1, 1'b0, 4'h3, 8'h00);
        tick();
        chk("t2_gnt1_rd", bus.gnt1, 1);
        chk("t2_we_rd",   ram_we,   0);
        clr_req(1);
        tick();
        chk("t2_read_strobes", {ram_cs, ram_we, ram_rd}, 3'b101);
        tick();
        chk("t2_rvalid1", bus.rvalid1, 1);
        chk("t2_rvalid0", bus.rvalid0, 0);
        chk("t2_rdata",   bus.rdata,   8'hA5);
        chk("t2_resp_cs", ram_cs,      0);
        tick();
        chk("t2_end", {busy, bus.rvalid1}, 0);

        // Simultaneous requests, four rounds
        set_req(0, 1'b1, 4'h8, 8'h10);
        set_req(1, 1'b1, 4'h9, 8'h20);
        for (int r = 0; r < 4; r++) begin
            wait_gnt(who);
            chk("t3_tie_winner", who, exp_tie[r]);
            if (r == 3) begin
                clr_req(0);
                clr_req(1);
            end else begin
                clr_req(who);
                tick();
                if (who == 0) set_req(0, 1'b1, 4'h8, 8'h10);
                else          set_req(1, 1'b1, 4'h9, 8'h20);
            end
        end
        tick();
        tick();
        chk("t3_idle", busy, 0);

        // req1 arriving during a port 0 read waits for the read to finish
        set_req(0, 1'b0, 4'h3, 8'h00);
        wait_gnt(who);
        chk("t4_gnt_port", who, 0);
        clr_req(0);
        tick();
        set_req(1, 1'b1, 4'h6, 8'h5A);
        chk("t4_gnt1_in_read", bus.gnt1, 0);
        tick();
        chk("t4_gnt1_in_resp", bus.gnt1,    0);
        chk("t4_rvalid0",      bus.rvalid0, 1);
        chk("t4_rdata",        bus.rdata,   8'hA5);
        chk("t4_resp_cs",      ram_cs,      0);
        tick();
        chk("t4_gnt1_idle", {busy, bus.gnt1}, 0);
        tick();
        chk("t4_gnt1", bus.gnt1, 1);
        chk("t4_cs_addr", {ram_cs, ram_addr}, {1'b1, 4'h6});
        clr_req(1);
        tick();
        chk("t4_mem6", mem[6], 8'h5A);

        // Top address
        do_write(1, 4'hF, 8'hC3);
        chk("t5_memF", mem[15], 8'hC3);
        do_read(0, 4'hF, 8'hC3);

        // One-cycle request pulse still completes exactly once
        set_req(0, 1'b0, 4'h6, 8'h00);
        tick();
        clr_req(0);
        g_cnt = int'(bus.gnt0);
        r_cnt = 0;
        cap   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.gnt0) g_cnt++;
            if (bus.rvalid0) begin r_cnt++; cap = bus.rdata; end
        end
        chk("t6_gnt0_count",   g_cnt, 1);
        chk("t6_rvalid0_count", r_cnt, 1);
        chk("t6_rdata",        cap,   8'h5A);

        // Reset asserted while in READ
        set_req(0, 1'b0, 4'hF, 8'h00);
        wait_gnt(who);
        clr_req(0);
        tick();
        chk("t1_in_read", ram_rd, 1);
        RESET_N = 1'b0;
        #1;
        chk("t1_strobes", {ram_cs, ram_we, ram_rd}, 0);
        chk("t1_busy",    busy, 0);
        chk("t1_hs",      {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}, 0);
        chk("t1_rdata",   bus.rdata, 0);
        tick();
        tick();
        RESET_N = 1'b1;
        g_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1 || bus.rvalid0 || bus.rvalid1 || busy) g_cnt++;
        end
        chk("t1_quiet_after", g_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sram_access_arbiter
